// File: rtl/digit_serial_adder.sv
// Digit-serial add/subtract: one DIGIT-bit ripple slice reused over WIDTH/DIGIT cycles,
// with the carry held in a register between slices and a start/busy/done handshake.
module digit_serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_carry_in,
  input  logic             i_sub,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_carry_out,
  output logic             o_overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  generate
    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
      $error("digit_serial_adder: DIGIT must divide WIDTH exactly");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             w_accept, w_last;

  logic [DIGIT:0]         w_dsum;
  logic [WIDTH+DIGIT-1:0] w_cat;
  logic [WIDTH-1:0]       w_res_nxt;
  logic                   w_msb_cin;

  assign w_dsum    = {1'b0, r_a[DIGIT-1:0]} + {1'b0, r_b[DIGIT-1:0]} + {{DIGIT{1'b0}}, r_carry};
  assign w_cat     = {w_dsum[DIGIT-1:0], r_res};
  assign w_res_nxt = w_cat[WIDTH+DIGIT-1:DIGIT];
  // Carry into the top bit of the slice, recovered from its sum bit; only meaningful on the last digit.
  assign w_msb_cin = r_a[DIGIT-1] ^ r_b[DIGIT-1] ^ w_dsum[DIGIT-1];

  assign o_busy = (r_state == S_RUN);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      S_IDLE: if (i_start) begin
        w_accept    = 1'b1;
        w_state_nxt = S_RUN;
      end
      S_RUN: if (r_cnt == CW'(N - 1)) begin
        w_last      = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      o_done      <= 1'b0;
      o_sum       <= '0;
      o_carry_out <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      o_done <= w_last;
      if (w_accept) begin
        // Subtract is a + ~b + 1, so the inversion and the +1 are folded in at capture.
        r_a     <= i_a;
        r_b     <= i_sub ? ~i_b : i_b;
        r_carry <= i_carry_in ^ i_sub;
        r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
        r_a     <= r_a >> DIGIT;
        r_b     <= r_b >> DIGIT;
        r_res   <= w_res_nxt;
        r_carry <= w_dsum[DIGIT];
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_last) begin
        o_sum       <= w_res_nxt;
        o_carry_out <= w_dsum[DIGIT];
        o_overflow  <= w_msb_cin ^ w_dsum[DIGIT];
      end
    end
  end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Bench for digit_serial_adder: three instances (1/1, 8/1, 8/4) driven by directed and random
// operations, checked against a plain-arithmetic reference model.
module tb_digit_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] start, cin, sub;
  logic [7:0] a [3];
  logic [7:0] b [3];
  logic [2:0] busy, done, cout, ovf;
  logic       s0;
  logic [7:0] s1, s2;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  digit_serial_adder #(.WIDTH(1), .DIGIT(1)) u0 (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_a(a[0][0:0]), .i_b(b[0][0:0]),
    .i_carry_in(cin[0]), .i_sub(sub[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_sum(s0), .o_carry_out(cout[0]), .o_overflow(ovf[0]));

  digit_serial_adder #(.WIDTH(8), .DIGIT(1)) u1 (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_a(a[1]), .i_b(b[1]),
    .i_carry_in(cin[1]), .i_sub(sub[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_sum(s1), .o_carry_out(cout[1]), .o_overflow(ovf[1]));

  digit_serial_adder #(.WIDTH(8), .DIGIT(4)) u2 (
    .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_a(a[2]), .i_b(b[2]),
    .i_carry_in(cin[2]), .i_sub(sub[2]), .o_busy(busy[2]), .o_done(done[2]),
    .o_sum(s2), .o_carry_out(cout[2]), .o_overflow(ovf[2]));

  function automatic int wid(int k);
    return (k == 0) ? 1 : 8;
  endfunction

  function automatic int ndig(int k);
    return (k == 0) ? 1 : (k == 1) ? 8 : 2;
  endfunction

  function automatic int sum_of(int k);
    return (k == 0) ? int'(s0) : (k == 1) ? int'(s1) : int'(s2);
  endfunction

  // Returns {overflow, carry_out, sum[7:0]} from integer arithmetic and sign rules.
  function automatic logic [9:0] model(int w, logic [7:0] av, logic [7:0] bv, logic ci, logic sb);
    int unsigned mask, ea, eb, full, s, co, sa, sbb, ss, ov;
    mask = (32'd1 << w) - 1;
    ea   = av & mask;
    eb   = (sb ? 32'(~bv) : 32'(bv)) & mask;
    full = ea + eb + ((ci ^ sb) ? 1 : 0);
    s    = full & mask;
    co   = (full >> w) & 1;
    sa   = (ea >> (w - 1)) & 1;
    sbb  = (eb >> (w - 1)) & 1;
    ss   = (s >> (w - 1)) & 1;
    ov   = ((sa == sbb) && (ss != sa)) ? 1 : 0;
    return {ov[0], co[0], s[7:0]};
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int k, input int n0, output int n);
    n = n0;
    while (n < 60) begin
      @(posedge clk); #1;
      n++;
      if (done[k]) break;
    end
  endtask

  task automatic check_result(input int k, input logic [9:0] e);
    chk("sum", sum_of(k), int'(e[7:0]));
    chk("carry_out", int'(cout[k]), int'(e[8]));
    chk("overflow", int'(ovf[k]), int'(e[9]));
  endtask

  task automatic run_op(input int k, input logic [7:0] av, input logic [7:0] bv,
                        input logic ci, input logic sb);
    int n, bc;
    logic [9:0] e;
    e = model(wid(k), av, bv, ci, sb);
    @(negedge clk);
    a[k] = av; b[k] = bv; cin[k] = ci; sub[k] = sb; start[k] = 1'b1;
    @(posedge clk); #1;
    start[k] = 1'b0;
    n = 0; bc = 0;
    while (n < 60) begin
      if (busy[k]) bc++;
      @(posedge clk); #1;
      n++;
      if (done[k]) break;
    end
    chk("latency", n, ndig(k));
    chk("busy_cycles", bc, ndig(k));
    chk("busy_at_done", int'(busy[k]), 0);
    check_result(k, e);
    @(posedge clk); #1;
    chk("done_falls", int'(done[k]), 0);
    chk("sum_held", sum_of(k), int'(e[7:0]));
  endtask

  initial begin
    int n, dcnt;
    logic [9:0] e1, e2;
    rst = 1'b1; start = '0; cin = '0; sub = '0;
    for (int k = 0; k < 3; k++) begin a[k] = '0; b[k] = '0; end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_busy", int'(busy[k]), 0);
      chk("rst_done", int'(done[k]), 0);
      chk("rst_sum", sum_of(k), 0);
      chk("rst_cout", int'(cout[k]), 0);
      chk("rst_ovf", int'(ovf[k]), 0);
    end
    @(negedge clk); rst = 1'b0;

    // Full-adder truth table on the 1-bit instance.
    for (int i = 0; i < 8; i++) run_op(0, 8'(i & 1), 8'((i >> 1) & 1), 1'((i >> 2) & 1), 1'b0);

    run_op(1, 8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0);
    chk("7F+01_sum_const", int'(s1), 'h80);
    chk("7F+01_ovf_const", int'(ovf[1]), 1);
    run_op(1, 8'h05, 8'h07, 1'b0, 1'b1);
    chk("05-07_sum_const", int'(s1), 'hFE);
    run_op(2, 8'hA5, 8'h5A, 1'b1, 1'b0);
    chk("A5+5A+1_cout_const", int'(cout[2]), 1);

    // Start pulse and operand changes in the 3rd busy cycle must not disturb the result.
    e1 = model(8, 8'h3C, 8'h21, 1'b0, 1'b0);
    @(negedge clk);
    a[1] = 8'h3C; b[1] = 8'h21; cin[1] = 1'b0; sub[1] = 1'b0; start[1] = 1'b1;
    @(posedge clk); #1; start[1] = 1'b0;
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    a[1] = 8'hFF; b[1] = 8'hFF; sub[1] = 1'b1; cin[1] = 1'b1; start[1] = 1'b1;
    @(posedge clk); #1; start[1] = 1'b0;
    wait_done(1, 3, n);
    chk("midrun_latency", n, 8);
    check_result(1, e1);
    @(posedge clk); #1;
    chk("midrun_not_queued", int'(busy[1]), 0);

    // Start held through the done cycle gives back-to-back operation.
    e1 = model(8, 8'h9C, 8'h47, 1'b1, 1'b1);
    e2 = model(8, 8'h80, 8'h01, 1'b0, 1'b1);
    @(negedge clk);
    a[2] = 8'h9C; b[2] = 8'h47; cin[2] = 1'b1; sub[2] = 1'b1; start[2] = 1'b1;
    @(posedge clk); #1;
    a[2] = 8'h80; b[2] = 8'h01; cin[2] = 1'b0; sub[2] = 1'b1;
    wait_done(2, 0, n);
    chk("b2b_first_latency", n, 2);
    check_result(2, e1);
    @(posedge clk); #1; start[2] = 1'b0;
    chk("b2b_accept", int'(busy[2]), 1);
    chk("b2b_done_low", int'(done[2]), 0);
    wait_done(2, 0, n);
    chk("b2b_second_latency", n, 2);
    check_result(2, e2);

    // Reset in the 4th RUN cycle aborts and clears outputs.
    run_op(1, 8'h7F, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    a[1] = 8'h12; b[1] = 8'h34; cin[1] = 1'b0; sub[1] = 1'b0; start[1] = 1'b1;
    @(posedge clk); #1; start[1] = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    chk("abort_busy", int'(busy[1]), 0);
    chk("abort_done", int'(done[1]), 0);
    chk("abort_sum", int'(s1), 0);
    chk("abort_cout", int'(cout[1]), 0);
    chk("abort_ovf", int'(ovf[1]), 0);
    @(negedge clk); rst = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done[1]) dcnt++;
    end
    chk("abort_no_done", dcnt, 0);
    run_op(1, 8'h12, 8'h34, 1'b1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      run_op(int'($urandom_range(0, 2)), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/digit_serial_adder.md
# digit_serial_adder

Multi-cycle, parametrised add/subtract unit built from a DIGIT-bit ripple slice that is reused over WIDTH/DIGIT clock cycles, with the carry held in a register between slices. It extends the single-bit full adder to arbitrary operand width, adds a subtract mode and signed-overflow detection, and uses a start/busy/done handshake. It sits in the datapath wherever area matters more than latency.

## Interface
- WIDTH, 8: operand and result width in bits; must be ≥1.
- DIGIT, 1: bits processed per cycle; must divide WIDTH exactly (elaboration error otherwise).
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A; captured on the accepting edge.
- b  input  WIDTH  operand B; captured on the accepting edge.
- carry_in  input  1  initial carry; captured on the accepting edge.
- sub  input  1  0 = add, 1 = subtract; captured on the accepting edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result; held until the next completion.
- carry_out  output  1  carry out of the MSB. In subtract mode, 1 means no borrow.
- overflow  output  1  signed two's-complement overflow of the last result.

## Operation
- States are IDLE and RUN. Reset enters IDLE with busy=0, done=0, sum=0, carry_out=0, overflow=0, and clears all internal registers.
- IDLE to RUN: on an edge with start=1 and busy=0:
  - Capture A←a and B←(sub ? ~b : b).
  - Set the carry register to carry_in XOR sub.
  - Load the digit counter with 0. busy rises.
- RUN, on each edge:
  - Add the low DIGIT bits of A, B and the carry.
  - Shift the result digit into the top of the internal result register.
  - Shift A and B right by DIGIT.
  - Store the new carry and increment the counter.
- The edge that processes the last digit (counter = WIDTH/DIGIT−1) returns the block to IDLE and updates the outputs:
  - busy falls and done rises.
  - sum, carry_out and overflow are loaded.
  - overflow = carry into the MSB XOR carry out of the MSB.
- done falls on the next edge. sum, carry_out and overflow hold until the next completion or reset.
- Arithmetic:
  - Add: {carry_out, sum} = a + b + carry_in.
  - Subtract: {carry_out, sum} = a + ~b + (carry_in XOR 1). sub=1 with carry_in=0 therefore gives a−b, and carry_in=1 acts as a borrow-in giving a−b−1.
- start while busy=1 is ignored. The request is not queued.
- Input changes during RUN have no effect, because operands are captured at acceptance.
- start=1 on the edge where done=1 (busy already 0) is accepted, giving back-to-back operation.
- Reset asserted mid-operation aborts immediately: busy=0, done never pulses for the aborted operation, and outputs clear to 0.
- WIDTH=DIGIT gives a single-cycle RUN, equivalent to a registered full-width adder.

## Timing
- Let N = WIDTH/DIGIT and let E0 be the accepting edge.
- busy is high from E0 to EN. done, sum, carry_out and overflow update at EN, so latency from start to result is N edges.
- done is high for exactly one cycle, between EN and EN+1.
- Maximum throughput is one result per N+1 cycles when the next start is held across the done cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.
- The critical path is a DIGIT-bit ripple carry plus the carry register.

## Test plan
- WIDTH=1, DIGIT=1, all 8 combinations of a/b/carry_in with sub=0 → sum and carry_out match the full-adder truth table; done arrives 1 edge after start each time.
- WIDTH=8, DIGIT=1, a=8'hFF, b=8'h01, cin=0 → sum=8'h00, carry_out=1, overflow=0; done 8 edges after the accepting edge; busy high for exactly 8 cycles.
- WIDTH=8, DIGIT=1:
  - a=8'h7F, b=8'h01 → sum=8'h80, carry_out=0, overflow=1.
  - Then sub=1, a=8'h05, b=8'h07, cin=0 → sum=8'hFE, carry_out=0, overflow=0.
- WIDTH=8, DIGIT=4, a=8'hA5, b=8'h5A, cin=1 → sum=8'h00, carry_out=1; done 2 edges after start.
- Handshake:
  - Pulse start again and change a/b on the 3rd busy cycle → no effect on the result.
  - Hold start through the done cycle → the second operation is accepted on that edge.
- Assert rst on the 4th RUN cycle → busy, done, sum, carry_out and overflow are all 0 immediately; no done pulse follows; the next start completes normally.
